// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad, debounces press and release, and emits one code per press.
// Optional auto-repeat while a key stays held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CNT = 50000,
  parameter int REPEAT_DLY   = 5000000,
  parameter int REPEAT_RATE  = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  if (SCAN_DIV < 4 || DEBOUNCE_CNT < 2 || REPEAT_DLY < 1 || REPEAT_RATE < 1) begin : g_bad_params
    $error("keypad_scanner: SCAN_DIV must be >= 4, DEBOUNCE_CNT >= 2, repeat timings >= 1");
  end

  typedef enum logic [2:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_PRESS,
    S_HELD,
    S_RELEASE
  } state_t;

  state_t           r_state;
  logic [3:0]       r_row_meta;
  logic [3:0]       r_row_sync;
  logic [1:0]       r_col;
  logic [3:0]       r_col_out;
  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_row;
  logic [3:0]       r_pattern;
  logic [3:0]       r_key;
  logic             r_key_valid;
  logic             r_key_held;

  logic [3:0]       w_pressed;
  logic [1:0]       w_low_row;
  logic             w_row_high;

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Rows are asynchronous to clock; everything downstream sees only r_row_sync.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_row_meta <= 4'hF;
      r_row_sync <= 4'hF;
    end else begin
      r_row_meta <= row_in;
      r_row_sync <= r_row_meta;
    end
  end

  assign w_pressed  = ~r_row_sync;
  assign w_row_high = r_row_sync[r_row];

  // NOTE: the default assignment before the loop keeps this purely combinational (no latch).
  always_comb begin
    w_low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_pressed[i]) w_low_row = 2'(i);
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_repeating;
  logic [HOLD_W-1:0] w_hold_target;

  assign w_hold_target = r_repeating ? HOLD_W'(REPEAT_RATE) : HOLD_W'(REPEAT_DLY);

  // Restarts at 1 after every repeat, so it never exceeds its target.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hold_cnt  <= '0;
      r_repeating <= 1'b0;
    end else if (r_state == S_PRESS) begin
      r_hold_cnt  <= HOLD_W'(1);
      r_repeating <= 1'b0;
    end else if (r_state == S_HELD && !w_row_high) begin
      if (r_hold_cnt == w_hold_target) begin
        r_hold_cnt  <= HOLD_W'(1);
        r_repeating <= 1'b1;
      end else begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
    end else begin
      r_hold_cnt  <= '0;
      r_repeating <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_SCAN;
      r_col       <= 2'd0;
      r_col_out   <= 4'b1110;
      r_div       <= '0;
      r_cnt       <= '0;
      r_row       <= 2'd0;
      r_pattern   <= 4'hF;
      r_key       <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      // NOTE: non-blocking default; a later assignment in the same cycle overrides it, giving a one-cycle pulse.
      r_key_valid <= 1'b0;
      unique case (r_state)
        S_SCAN: begin
          if (r_div == DIV_LAST) begin
            r_div <= '0;
            if (|w_pressed) begin
              r_pattern <= r_row_sync;
              r_row     <= w_low_row;
              r_cnt     <= '0;
              r_state   <= S_DEBOUNCE;
            end else begin
              r_col     <= r_col + 2'd1;
              r_col_out <= {r_col_out[2:0], r_col_out[3]};
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_DEBOUNCE: begin
          if (r_row_sync == r_pattern) begin
            if (r_cnt == CNT_LAST) begin
              r_cnt   <= '0;
              r_state <= S_PRESS;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_cnt     <= '0;
            r_col     <= r_col + 2'd1;
            r_col_out <= {r_col_out[2:0], r_col_out[3]};
            r_state   <= S_SCAN;
          end
        end
        S_PRESS: begin
          r_key       <= key_map(r_row, r_col);
          r_key_valid <= 1'b1;
          r_key_held  <= 1'b1;
          r_state     <= S_HELD;
        end
        S_HELD: begin
          // The cycle that first sees the row high counts as the first release sample.
          if (w_row_high) begin
            r_cnt   <= CNT_W'(1);
            r_state <= S_RELEASE;
          end
`ifdef KEYPAD_REPEAT_EN
          else if (r_hold_cnt == w_hold_target) begin
            r_key_valid <= 1'b1;
          end
`endif
        end
        S_RELEASE: begin
          if (w_row_high) begin
            if (r_cnt == CNT_LAST) begin
              r_cnt      <= '0;
              r_key_held <= 1'b0;
              r_col      <= r_col + 2'd1;
              r_col_out  <= {r_col_out[2:0], r_col_out[3]};
              r_state    <= S_SCAN;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_cnt <= '0;
          end
        end
        default: r_state <= S_SCAN;
      endcase
    end
  end

  assign col_out   = r_col_out;
  assign key       = r_key;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with a behavioural keypad matrix model.
// Auto-repeat expectations apply when KEYPAD_REPEAT_EN is defined.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DC = 8;
  localparam int RD = 40;
  localparam int RR = 20;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed = 16'h0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_pulse  = 0;
  int last_pulse_cyc = 0;
  logic [3:0] last_pulse_key = 4'h0;
  int pulse_q[$];

  typedef struct {
    int         row;
    int         col;
    logic [3:0] exp_key;
  } key_vec_t;

  keypad_scanner #(
    .SCAN_DIV    (SD),
    .DEBOUNCE_CNT(DC),
    .REPEAT_DLY  (RD),
    .REPEAT_RATE (RR)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .row_in   (row_in),
    .col_out  (col_out),
    .key      (key),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clock = ~clock;

  // A pressed key pulls its row low only while its column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  function automatic logic [15:0] kbit(input int r, input int c);
    return 16'(1) << (r * 4 + c);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (key_valid === 1'b1) begin
      n_pulse++;
      last_pulse_cyc = cyc;
      last_pulse_key = key;
      pulse_q.push_back(cyc);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  task automatic wait_pulse(input string name, input int budget);
    int start = n_pulse;
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (n_pulse != start) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_release(input string name, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (key_held === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    key_vec_t vecs[16];
    int rep_exp[4];
    int p0;
    int t0;

    vecs[0]  = '{0, 0, 4'h1}; vecs[1]  = '{0, 1, 4'h2}; vecs[2]  = '{0, 2, 4'h3}; vecs[3]  = '{0, 3, 4'hA};
    vecs[4]  = '{1, 0, 4'h4}; vecs[5]  = '{1, 1, 4'h5}; vecs[6]  = '{1, 2, 4'h6}; vecs[7]  = '{1, 3, 4'hB};
    vecs[8]  = '{2, 0, 4'h7}; vecs[9]  = '{2, 1, 4'h8}; vecs[10] = '{2, 2, 4'h9}; vecs[11] = '{2, 3, 4'hC};
    vecs[12] = '{3, 0, 4'hE}; vecs[13] = '{3, 1, 4'h0}; vecs[14] = '{3, 2, 4'hF}; vecs[15] = '{3, 3, 4'hD};
    rep_exp = '{40, 60, 80, 100};

    // Reset values and idle scan rotation
    #2 reset = 1'b0;
    repeat (2) tick();
    check("rst_col_out", 32'(col_out), 32'hE);
    check("rst_key", 32'(key), 32'h0);
    check("rst_key_valid", 32'(key_valid), 32'h0);
    check("rst_key_held", 32'(key_held), 32'h0);
    reset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      logic [3:0] exp_col;
      repeat (4) tick();
      exp_col = ~(4'b0001 << (i % 4));
      check($sformatf("idle_col_%0d", i), 32'(col_out), 32'(exp_col));
    end
    check("idle_no_pulse", 32'(n_pulse), 32'd0);
    check("idle_key", 32'(key), 32'h0);

    // Clean press of key 9, then release debounce timing
    p0 = n_pulse;
    pressed = kbit(2, 2);
    repeat (40) tick();
    check("k9_pulses", 32'(n_pulse - p0), 32'd1);
    check("k9_key", 32'(last_pulse_key), 32'h9);
    check("k9_held", 32'(key_held), 32'h1);
    pressed = 16'h0;
    repeat (8) tick();
    check("k9_held_during_release", 32'(key_held), 32'h1);
    repeat (3) tick();
    check("k9_held_cleared", 32'(key_held), 32'h0);
    check("k9_key_kept", 32'(key), 32'h9);
    check("k9_no_extra_pulse", 32'(n_pulse - p0), 32'd1);

    // Bouncing key 0: 3 on / 2 off for 15 cycles, then stable
    p0 = n_pulse;
    for (int k = 0; k < 15; k++) begin
      pressed = ((k % 5) < 3) ? kbit(3, 1) : 16'h0;
      tick();
    end
    pressed = kbit(3, 1);
    t0 = cyc;
    repeat (40) tick();
    check("k0_pulses", 32'(n_pulse - p0), 32'd1);
    check("k0_key", 32'(last_pulse_key), 32'h0);
    check("k0_not_early", 32'(last_pulse_cyc - t0 >= DC), 32'd1);
    pressed = 16'h0;
    wait_release("k0_release", 30);

    // Keys A and 1 together from column 0: 1 wins, no pulse for A
    apply_reset();
    p0 = n_pulse;
    pressed = kbit(0, 0) | kbit(0, 3);
    wait_pulse("dual_first_pulse", 60);
    check("dual_key", 32'(key), 32'h1);
    repeat (20) tick();
    check("dual_one_pulse_held", 32'(n_pulse - p0), 32'd1);
    pressed = 16'h0;
    repeat (12) tick();
    check("dual_released", 32'(key_held), 32'h0);
    repeat (24) tick();
    check("dual_one_pulse_total", 32'(n_pulse - p0), 32'd1);

    // Reset in the middle of debouncing key D
    apply_reset();
    p0 = n_pulse;
    pressed = kbit(3, 3);
    repeat (19) tick();
    check("mid_db_no_pulse", 32'(n_pulse - p0), 32'd0);
    check("mid_db_col_frozen", 32'(col_out), 32'h7);
    reset = 1'b0;
    #1;
    check("async_rst_col_out", 32'(col_out), 32'hE);
    check("async_rst_key", 32'(key), 32'h0);
    check("async_rst_key_valid", 32'(key_valid), 32'h0);
    check("async_rst_key_held", 32'(key_held), 32'h0);
    pressed = 16'h0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (30) tick();
    check("post_rst_no_pulse", 32'(n_pulse - p0), 32'd0);
    pressed = kbit(3, 3);
    t0 = cyc;
    wait_pulse("post_rst_pulse", 60);
    check("post_rst_key", 32'(key), 32'hD);
    check("post_rst_latency", 32'(last_pulse_cyc - t0 >= DC + 2), 32'd1);
    pressed = 16'h0;
    wait_release("post_rst_release", 30);

    // Long hold of key C: auto-repeat schedule (or a single pulse)
    apply_reset();
    pressed = kbit(2, 3);
    wait_pulse("hold_first_pulse", 60);
    check("hold_key", 32'(key), 32'hC);
    p0 = last_pulse_cyc;
    pulse_q.delete();
    repeat (102) tick();
`ifdef KEYPAD_REPEAT_EN
    check("repeat_count", 32'(pulse_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < pulse_q.size(); i++) begin
      check($sformatf("repeat_offset_%0d", i), 32'(pulse_q[i] - p0), 32'(rep_exp[i]));
    end
`else
    check("repeat_none", 32'(pulse_q.size()), 32'd0);
`endif
    check("hold_key_kept", 32'(key), 32'hC);
    pressed = 16'h0;
    wait_release("hold_release", 30);

    // Full key map, one press per key from a fresh reset
    for (int v = 0; v < 16; v++) begin
      apply_reset();
      p0 = n_pulse;
      pressed = kbit(vecs[v].row, vecs[v].col);
      wait_pulse($sformatf("map_pulse_r%0dc%0d", vecs[v].row, vecs[v].col), 60);
      check($sformatf("map_key_r%0dc%0d", vecs[v].row, vecs[v].col), 32'(key), 32'(vecs[v].exp_key));
      check($sformatf("map_held_r%0dc%0d", vecs[v].row, vecs[v].col), 32'(key_held), 32'h1);
      pressed = 16'h0;
      wait_release($sformatf("map_release_r%0dc%0d", vecs[v].row, vecs[v].col), 30);
      check($sformatf("map_single_r%0dc%0d", vecs[v].row, vecs[v].col), 32'(n_pulse - p0), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
